dac_spi_transmitter: RTL and testbench

//  Downstream end of the EnvelopeFollower sample path: captures each 12-bit sample announced by a

---
 rtl/dac_spi_transmitter_if.sv | 23 ++
 rtl/dac_spi_transmitter.sv | 174 +++++++++++++++++
 tb/tb_dac_spi_transmitter.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_spi_transmitter_if.sv
// Sample-in / SPI-out signal bundle for dac_spi_transmitter.
// The master side drives the sample and strobe and observes the DAC pins. The slave side is the transmitter.
interface dac_spi_transmitter_if;
    logic [11:0] inSample;
    logic        inSampleReady;
    logic        dacEnable;
    logic        spiCsN;
    logic        spiSck;
    logic        spiMosi;
    logic        dacLdacN;
    logic        busy;
    logic        overrun;

    modport master (
        output inSample, inSampleReady, dacEnable,
        input  spiCsN, spiSck, spiMosi, dacLdacN, busy, overrun
    );

    modport slave (
        input  inSample, inSampleReady, dacEnable,
        output spiCsN, spiSck, spiMosi, dacLdacN, busy, overrun
    );
endinterface

// File: rtl/dac_spi_transmitter.sv
// Sends each strobed 12-bit sample to an MCP4921-class DAC (SPI mode 0, 16-bit frame), then pulses LDAC.
// A one-deep pending buffer holds a sample that arrives while a frame is in flight.
module dac_spi_transmitter #(
    parameter int CLK_DIV = 2,
    parameter bit BUF     = 1'b0,
    parameter bit GAIN_1X = 1'b1
) (
    input logic                  clk,
    input logic                  reset,
    dac_spi_transmitter_if.slave bus
);
    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_CS_HOLD,
        S_GAP,
        S_LDAC
    } state_t;

    state_t           r_state;
    logic             r_sync_1;
    logic             r_sync_2;
    logic             r_sync_d;
    logic [15:0]      r_frame;
    logic [15:0]      r_pending;
    logic             r_pending_valid;
    logic [DIV_W-1:0] r_div;
    logic             r_sck_high;
    logic [3:0]       r_bit_cnt;
    logic             r_cs_n;
    logic             r_sck;
    logic             r_mosi;
    logic             r_ldac_n;
    logic             r_busy;
    logic             r_overrun;

    logic             w_edge;
    logic             w_div_last;
    logic             w_ldac_end;
    logic             w_start;
    logic [15:0]      w_word;
    logic [15:0]      w_launch;

    assign w_edge     = r_sync_2 & ~r_sync_d;
    assign w_div_last = (r_div == DIV_LAST);
    assign w_ldac_end = (r_state == S_LDAC) && w_div_last;
    assign w_word     = {1'b0, BUF, GAIN_1X, bus.dacEnable, bus.inSample};
    // Pending is only ever valid while busy, so in IDLE the launch word is always the live sample.
    assign w_launch   = r_pending_valid ? r_pending : w_word;
    assign w_start    = ((r_state == S_IDLE) && w_edge) ||
                        (w_ldac_end && (r_pending_valid || w_edge));

    assign bus.spiCsN   = r_cs_n;
    assign bus.spiSck   = r_sck;
    assign bus.spiMosi  = r_mosi;
    assign bus.dacLdacN = r_ldac_n;
    assign bus.busy     = r_busy;
    assign bus.overrun  = r_overrun;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync_1 <= 1'b0;
            r_sync_2 <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync_1 <= bus.inSampleReady;
            r_sync_2 <= r_sync_1;
            r_sync_d <= r_sync_2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_frame         <= '0;
            r_pending       <= '0;
            r_pending_valid <= 1'b0;
            r_div           <= '0;
            r_sck_high      <= 1'b0;
            r_bit_cnt       <= 4'd0;
            r_cs_n          <= 1'b1;
            r_sck           <= 1'b0;
            r_mosi          <= 1'b0;
            r_ldac_n        <= 1'b1;
            r_busy          <= 1'b0;
            r_overrun       <= 1'b0;
        end else begin
            r_overrun <= 1'b0;

            if (r_state == S_IDLE || w_div_last) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                end
                S_SHIFT: begin
                    if (w_div_last) begin
                        if (!r_sck_high) begin
                            r_sck_high <= 1'b1;
                            r_sck      <= 1'b1;
                        end else begin
                            r_sck_high <= 1'b0;
                            r_sck      <= 1'b0;
                            if (r_bit_cnt == 4'd0) begin
                                r_state <= S_CS_HOLD;
                                r_mosi  <= 1'b0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt - 4'd1;
                                r_mosi    <= r_frame[r_bit_cnt - 4'd1];
                            end
                        end
                    end
                end
                S_CS_HOLD: begin
                    if (w_div_last) begin
                        r_state <= S_GAP;
                        r_cs_n  <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (w_div_last) begin
                        r_state  <= S_LDAC;
                        r_ldac_n <= 1'b0;
                    end
                end
                S_LDAC: begin
                    if (w_div_last) begin
                        r_ldac_n <= 1'b1;
                        if (!r_pending_valid && !w_edge) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            if (w_start) begin
                r_state         <= S_SHIFT;
                r_frame         <= w_launch;
                r_bit_cnt       <= 4'd15;
                r_sck_high      <= 1'b0;
                r_sck           <= 1'b0;
                r_cs_n          <= 1'b0;
                r_mosi          <= w_launch[15];
                r_busy          <= 1'b1;
                r_pending_valid <= 1'b0;
            end

            // Edge while busy parks the word; at the hand-over cycle the buffer was just emptied, so no overrun.
            if (w_edge && r_state != S_IDLE) begin
                if (w_ldac_end) begin
                    if (r_pending_valid) begin
                        r_pending       <= w_word;
                        r_pending_valid <= 1'b1;
                    end
                end else begin
                    r_pending       <= w_word;
                    r_pending_valid <= 1'b1;
                    r_overrun       <= r_pending_valid;
                end
            end
        end
    end
endmodule

// File: tb/tb_dac_spi_transmitter.sv
// Directed bench: one CLK_DIV=2 transmitter for framing/pending/abort, one CLK_DIV=1 for streaming.
// Pin monitors rebuild frames from MOSI on SCK rises and record CS/LDAC timing.
module tb_dac_spi_transmitter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dac_spi_transmitter_if bus2 ();
    dac_spi_transmitter_if bus1 ();

    dac_spi_transmitter #(.CLK_DIV(2), .BUF(1'b0), .GAIN_1X(1'b1)) u_dut2 (
        .clk(clk), .reset(reset), .bus(bus2.slave)
    );
    dac_spi_transmitter #(.CLK_DIV(1), .BUF(1'b0), .GAIN_1X(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] fr2_q[$];
    int          nb2_q[$];
    int          cl2_q[$];
    int          fall2_q[$];
    int          ldd2_q[$];
    int          ldw2_q[$];
    logic [15:0] fr1_q[$];
    int          nb1_q[$];
    int          cl1_q[$];
    int          cyc     = 0;
    int          ov2_cnt = 0;
    int          ov1_cnt = 0;
    int          nb2_cur = 0;

    initial begin : mon2
        logic p_cs, p_sck, p_ldac;
        logic [15:0] sh;
        int nb, cl, since, lw;
        p_cs = 1'b1; p_sck = 1'b0; p_ldac = 1'b1; sh = '0; nb = 0; cl = 0; since = 0; lw = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (p_cs && !bus2.spiCsN) begin
                sh = '0; nb = 0; cl = 0;
                fall2_q.push_back(cyc);
            end
            if (!p_sck && bus2.spiSck && !bus2.spiCsN) begin
                sh = {sh[14:0], bus2.spiMosi};
                nb++;
            end
            if (!bus2.spiCsN) cl++;
            if (!p_cs && bus2.spiCsN) begin
                fr2_q.push_back(sh); nb2_q.push_back(nb); cl2_q.push_back(cl);
                since = 0;
            end else begin
                since++;
            end
            if (p_ldac && !bus2.dacLdacN) begin
                ldd2_q.push_back(since);
                lw = 0;
            end
            if (!bus2.dacLdacN) lw++;
            if (!p_ldac && bus2.dacLdacN) ldw2_q.push_back(lw);
            if (bus2.overrun) ov2_cnt++;
            nb2_cur = nb;
            p_cs = bus2.spiCsN; p_sck = bus2.spiSck; p_ldac = bus2.dacLdacN;
        end
    end

    initial begin : mon1
        logic p_cs, p_sck;
        logic [15:0] sh;
        int nb, cl;
        p_cs = 1'b1; p_sck = 1'b0; sh = '0; nb = 0; cl = 0;
        forever begin
            @(negedge clk);
            if (p_cs && !bus1.spiCsN) begin
                sh = '0; nb = 0; cl = 0;
            end
            if (!p_sck && bus1.spiSck && !bus1.spiCsN) begin
                sh = {sh[14:0], bus1.spiMosi};
                nb++;
            end
            if (!bus1.spiCsN) cl++;
            if (!p_cs && bus1.spiCsN) begin
                fr1_q.push_back(sh); nb1_q.push_back(nb); cl1_q.push_back(cl);
            end
            if (bus1.overrun) ov1_cnt++;
            p_cs = bus1.spiCsN; p_sck = bus1.spiSck;
        end
    end

    function automatic int q_size(input int which);
        case (which)
            0:       return fr2_q.size();
            1:       return ldw2_q.size();
            default: return fr1_q.size();
        endcase
    endfunction

    task automatic wait_until(input int which, input int target, input string tag);
        int t;
        t = 0;
        while (q_size(which) < target && t < 3000) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (q_size(which) < target) begin
            n_fail++;
            $display("FAIL %s: seen %0d events, required %0d", tag, q_size(which), target);
        end
    endtask

    task automatic pulse2(input logic [11:0] s, input logic en);
        @(negedge clk);
        #2;
        bus2.inSample      = s;
        bus2.dacEnable     = en;
        bus2.inSampleReady = 1'b1;
        repeat (6) @(negedge clk);
        #2 bus2.inSampleReady = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus2.inSample = '0; bus2.inSampleReady = 1'b0; bus2.dacEnable = 1'b0;
        bus1.inSample = '0; bus1.inSampleReady = 1'b0; bus1.dacEnable = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus2.spiCsN !== 1'b1) begin n_fail++; $display("FAIL reset_csn: got %b, want 1", bus2.spiCsN); end
        n_checks++;
        if (bus2.spiSck !== 1'b0) begin n_fail++; $display("FAIL reset_sck: got %b, want 0", bus2.spiSck); end
        n_checks++;
        if (bus2.spiMosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b, want 0", bus2.spiMosi); end
        n_checks++;
        if (bus2.dacLdacN !== 1'b1) begin n_fail++; $display("FAIL reset_ldac: got %b, want 1", bus2.dacLdacN); end
        n_checks++;
        if (bus2.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, want 0", bus2.busy); end
        n_checks++;
        if (bus2.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b, want 0", bus2.overrun); end
        n_checks++;
        if ({bus1.spiCsN, bus1.spiSck, bus1.spiMosi, bus1.dacLdacN, bus1.busy, bus1.overrun} !== 6'b100100) begin
            n_fail++;
            $display("FAIL reset_dut1: got %b, want 100100",
                     {bus1.spiCsN, bus1.spiSck, bus1.spiMosi, bus1.dacLdacN, bus1.busy, bus1.overrun});
        end
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_frame;
        int b, lb, ov0;
        b = fr2_q.size(); lb = ldw2_q.size(); ov0 = ov2_cnt;
        pulse2(12'hAFF, 1'b1);
        wait_until(0, b + 1, "single_frame_done");
        wait_until(1, lb + 1, "single_ldac_done");
        n_checks++;
        if (fr2_q[b] !== 16'h3AFF) begin n_fail++; $display("FAIL single_word: got %h, want 3aff", fr2_q[b]); end
        n_checks++;
        if (nb2_q[b] != 16) begin n_fail++; $display("FAIL single_sck_rises: got %0d, want 16", nb2_q[b]); end
        n_checks++;
        if (cl2_q[b] != 66) begin n_fail++; $display("FAIL single_cs_low: got %0d, want 66", cl2_q[b]); end
        n_checks++;
        if (ldd2_q[lb] != 2) begin n_fail++; $display("FAIL single_ldac_delay: got %0d, want 2", ldd2_q[lb]); end
        n_checks++;
        if (ldw2_q[lb] != 2) begin n_fail++; $display("FAIL single_ldac_width: got %0d, want 2", ldw2_q[lb]); end
        @(negedge clk);
        #1;
        n_checks++;
        if (bus2.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_drop: got %b, want 0", bus2.busy); end
        n_checks++;
        if (ov2_cnt != ov0) begin n_fail++; $display("FAIL single_overrun: got %0d pulses, want 0", ov2_cnt - ov0); end
    endtask

    task automatic test_disable_and_fall;
        int b;
        b = fr2_q.size();
        @(negedge clk);
        #2;
        bus2.inSample = 12'h123; bus2.dacEnable = 1'b0; bus2.inSampleReady = 1'b1;
        wait_until(0, b + 1, "disable_frame_done");
        n_checks++;
        if (fr2_q[b] !== 16'h2123) begin n_fail++; $display("FAIL disable_word: got %h, want 2123", fr2_q[b]); end
        repeat (10) @(negedge clk);
        #2 bus2.inSampleReady = 1'b0;
        repeat (150) @(negedge clk);
        n_checks++;
        if (fr2_q.size() != b + 1) begin
            n_fail++;
            $display("FAIL falling_edge_ignored: got %0d frames, want %0d", fr2_q.size() - b, 1);
        end
        n_checks++;
        if (bus2.busy !== 1'b0) begin n_fail++; $display("FAIL falling_edge_busy: got %b, want 0", bus2.busy); end
    endtask

    task automatic test_pending;
        int b, fb, ov0;
        b = fr2_q.size(); fb = fall2_q.size(); ov0 = ov2_cnt;
        pulse2(12'h0AA, 1'b1);
        repeat (15) @(negedge clk);
        pulse2(12'h100, 1'b1);
        wait_until(0, b + 2, "pending_frames_done");
        n_checks++;
        if (fr2_q[b] !== 16'h30AA) begin n_fail++; $display("FAIL pending_first: got %h, want 30aa", fr2_q[b]); end
        n_checks++;
        if (fr2_q[b + 1] !== 16'h3100) begin n_fail++; $display("FAIL pending_second: got %h, want 3100", fr2_q[b + 1]); end
        n_checks++;
        if (fall2_q[fb + 1] - fall2_q[fb] != 70) begin
            n_fail++;
            $display("FAIL pending_back_to_back: got %0d cycles, want 70", fall2_q[fb + 1] - fall2_q[fb]);
        end
        n_checks++;
        if (ov2_cnt != ov0) begin n_fail++; $display("FAIL pending_no_overrun: got %0d pulses, want 0", ov2_cnt - ov0); end
        repeat (100) @(negedge clk);

        b = fr2_q.size(); ov0 = ov2_cnt;
        pulse2(12'h0BB, 1'b1);
        pulse2(12'h200, 1'b1);
        pulse2(12'h300, 1'b1);
        wait_until(0, b + 2, "overrun_frames_done");
        repeat (200) @(negedge clk);
        n_checks++;
        if (fr2_q[b] !== 16'h30BB) begin n_fail++; $display("FAIL overrun_first: got %h, want 30bb", fr2_q[b]); end
        n_checks++;
        if (fr2_q[b + 1] !== 16'h3300) begin n_fail++; $display("FAIL overrun_kept: got %h, want 3300", fr2_q[b + 1]); end
        n_checks++;
        if (fr2_q.size() != b + 2) begin n_fail++; $display("FAIL overrun_frame_count: got %0d, want 2", fr2_q.size() - b); end
        n_checks++;
        if (ov2_cnt - ov0 != 1) begin n_fail++; $display("FAIL overrun_pulse: got %0d cycles, want 1", ov2_cnt - ov0); end
    endtask

    task automatic test_abort;
        int b, t;
        b = fr2_q.size();
        pulse2(12'h0A5, 1'b1);
        t = 0;
        while (nb2_cur != 9 && t < 300) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (nb2_cur != 9) begin n_fail++; $display("FAIL abort_reach_bit7: got %0d rises, want 9", nb2_cur); end
        #2;
        reset = 1'b1;
        bus2.inSample = 12'hFFF; bus2.inSampleReady = 1'b1;
        bus1.inSample = 12'hFFF; bus1.inSampleReady = 1'b1;
        #1;
        n_checks++;
        if (bus2.spiCsN !== 1'b1) begin n_fail++; $display("FAIL abort_csn: got %b, want 1", bus2.spiCsN); end
        n_checks++;
        if ({bus2.spiSck, bus2.spiMosi, bus2.busy, bus2.dacLdacN} !== 4'b0001) begin
            n_fail++;
            $display("FAIL abort_outputs: got %b, want 0001", {bus2.spiSck, bus2.spiMosi, bus2.busy, bus2.dacLdacN});
        end
        #1;
        bus2.inSampleReady = 1'b0;
        bus1.inSampleReady = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        wait_until(0, b + 1, "abort_partial_seen");
        n_checks++;
        if (nb2_q[b] >= 16) begin n_fail++; $display("FAIL abort_short: got %0d rises, want below 16", nb2_q[b]); end
        repeat (5) @(negedge clk);
        pulse2(12'h555, 1'b1);
        wait_until(0, b + 2, "abort_recovery_done");
        n_checks++;
        if (fr2_q[b + 1] !== 16'h3555) begin n_fail++; $display("FAIL abort_recovery_word: got %h, want 3555", fr2_q[b + 1]); end
        n_checks++;
        if (nb2_q[b + 1] != 16 || cl2_q[b + 1] != 66) begin
            n_fail++;
            $display("FAIL abort_recovery_shape: got %0d rises %0d low, want 16 66", nb2_q[b + 1], cl2_q[b + 1]);
        end
        repeat (50) @(negedge clk);
    endtask

    // Strobe spacing of 40 clk stays above the 35-cycle frame period at CLK_DIV=1, so nothing overruns.
    task automatic test_stream;
        int b, ov0;
        logic [11:0] s;
        b = fr1_q.size(); ov0 = ov1_cnt;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #2;
            bus1.inSample = 12'h010 + 12'(10 * i); bus1.dacEnable = 1'b1; bus1.inSampleReady = 1'b1;
            repeat (20) @(negedge clk);
            #2 bus1.inSampleReady = 1'b0;
            repeat (19) @(negedge clk);
        end
        wait_until(2, b + 8, "stream_frames_done");
        for (int i = 0; i < 8; i++) begin
            s = 12'h010 + 12'(10 * i);
            n_checks++;
            if (fr1_q[b + i] !== {4'h3, s}) begin
                n_fail++;
                $display("FAIL stream_word_%0d: got %h, want %h", i, fr1_q[b + i], {4'h3, s});
            end
            n_checks++;
            if (cl1_q[b + i] != 33 || nb1_q[b + i] != 16) begin
                n_fail++;
                $display("FAIL stream_shape_%0d: got %0d low %0d rises, want 33 16", i, cl1_q[b + i], nb1_q[b + i]);
            end
        end
        n_checks++;
        if (ov1_cnt != ov0) begin n_fail++; $display("FAIL stream_overrun: got %0d pulses, want 0", ov1_cnt - ov0); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_disable_and_fall();
        test_pending();
        test_abort();
        test_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
